// File: rtl/phase_sequencer.sv
// Multi-phase machine-cycle sequencer: walks one-hot phase enables through
// NUM_PHASES clocks per cycle, with halt/step/restart control and a completed-cycle counter.
module phase_sequencer #(
  parameter  int NUM_PHASES = 3,
  parameter  int CNT_W      = 16,
  localparam int IDX_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  step,
  input  logic                  restart,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  cycle_last,
  output logic                  running,
  output logic [CNT_W-1:0]      cycle_count
);

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] phase_idx_q, phase_idx_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic active;
  logic at_last;

  assign active  = (state_q != HALTED);
  assign at_last = (phase_idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HALTED;
      phase_idx_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_idx_q   <= phase_idx_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // RUN and STEP advance identically; they differ only in how they were entered.
  always_comb begin
    state_d       = state_q;
    phase_idx_d   = phase_idx_q;
    cycle_count_d = cycle_count_q;
    if (restart) begin
      phase_idx_d = '0;
      state_d     = halt ? HALTED : RUN;
    end else begin
      unique case (state_q)
        HALTED: begin
          phase_idx_d = '0;
          if (!halt)     state_d = RUN;
          else if (step) state_d = STEP;
        end
        RUN, STEP: begin
          if (at_last) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
            phase_idx_d   = '0;
            state_d       = halt ? HALTED : RUN;
          end else begin
            phase_idx_d = phase_idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d     = HALTED;
          phase_idx_d = '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches them combinationally.
  always_comb begin
    phase_en = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      phase_en[i] = active && (phase_idx_q == IDX_W'(i));
    end
  end

  assign phase_idx   = phase_idx_q;
  assign cycle_last  = phase_en[NUM_PHASES-1];
  assign running     = active;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomised bench for phase_sequencer: two instances (3-phase/16-bit, 5-phase/8-bit)
// share stimulus and are compared every clock against a behavioural cycle model.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halt = 1'b0;
  logic step = 1'b0;
  logic restart = 1'b0;

  always #5 clk = ~clk;

  logic [2:0]  pe3;
  logic [1:0]  idx3;
  logic        last3, run3;
  logic [15:0] cnt3;
  logic [4:0]  pe5;
  logic [2:0]  idx5;
  logic        last5, run5;
  logic [7:0]  cnt5;

  phase_sequencer #(.NUM_PHASES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .halt(halt), .step(step), .restart(restart),
    .phase_en(pe3), .phase_idx(idx3), .cycle_last(last3), .running(run3),
    .cycle_count(cnt3)
  );

  phase_sequencer #(.NUM_PHASES(5), .CNT_W(8)) dut5 (
    .clk(clk), .reset(reset), .halt(halt), .step(step), .restart(restart),
    .phase_en(pe5), .phase_idx(idx5), .cycle_last(last5), .running(run5),
    .cycle_count(cnt5)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a sequencer is either executing a cycle (at some position) or idle.
  int     np[2]   = '{3, 5};
  longint cmod[2] = '{65536, 256};
  bit     m_act[2];
  int     m_pos[2];
  longint m_cnt[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0;
      m_pos[k] = 0;
      m_cnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_act[k] = 1'b0;
        m_pos[k] = 0;
        m_cnt[k] = 0;
      end else if (restart) begin
        m_pos[k] = 0;
        m_act[k] = !halt;
      end else if (!m_act[k]) begin
        m_pos[k] = 0;
        m_act[k] = !halt || step;
      end else if (m_pos[k] == np[k] - 1) begin
        m_cnt[k] = (m_cnt[k] + 1) % cmod[k];
        m_pos[k] = 0;
        m_act[k] = !halt;
      end else begin
        m_pos[k] = m_pos[k] + 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] e_pe3, e_pe5;
    e_pe3 = m_act[0] ? (32'd1 << m_pos[0]) : 32'd0;
    e_pe5 = m_act[1] ? (32'd1 << m_pos[1]) : 32'd0;
    check_val("p3.phase_en",    32'(pe3),   e_pe3);
    check_val("p3.phase_idx",   32'(idx3),  32'(m_pos[0]));
    check_val("p3.cycle_last",  32'(last3), 32'(m_act[0] && m_pos[0] == 2));
    check_val("p3.running",     32'(run3),  32'(m_act[0]));
    check_val("p3.cycle_count", 32'(cnt3),  32'(m_cnt[0]));
    check_val("p5.phase_en",    32'(pe5),   e_pe5);
    check_val("p5.phase_idx",   32'(idx5),  32'(m_pos[1]));
    check_val("p5.cycle_last",  32'(last5), 32'(m_act[1] && m_pos[1] == 4));
    check_val("p5.running",     32'(run5),  32'(m_act[1]));
    check_val("p5.cycle_count", 32'(cnt5),  32'(m_cnt[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Pulse reset between edges and verify the asynchronous clear before the next edge.
  task automatic async_reset_pulse();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_p3_pos(input int pos);
    int n;
    n = 0;
    while (!(m_act[0] && m_pos[0] == pos) && n < 10) begin
      tick();
      n++;
    end
    check_val("wait_p3_pos_timeout", 32'(n < 10), 32'd1);
  endtask

  logic [15:0] saved_cnt;
  bit wrapped_seen;

  initial begin
    model_reset();
    #1;
    compare_all();

    // Reset held: outputs stay cleared whatever the controls do.
    halt = 1'b0; step = 1'b1; restart = 1'b1;
    repeat (3) tick();
    step = 1'b0; restart = 1'b0;

    // Release with halt low: free-running 001,010,100,001...
    reset = 1'b0;
    tick();
    check_val("first_phase_after_reset", 32'(pe3), 32'b001);
    repeat (6) tick();

    // Halt raised mid-cycle: cycle finishes, then idle.
    wait_p3_pos(1);
    halt = 1'b1;
    tick();
    check_val("halt_cycle_completes", 32'(pe3), 32'b100);
    tick();
    check_val("halt_stops", 32'(pe3), 32'b000);
    repeat (6) tick();

    // Single step pulse, then step held for ten clocks.
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (8) tick();
    step = 1'b1;
    repeat (10) tick();
    step = 1'b0;
    repeat (8) tick();

    // One-clock latency when halt falls.
    halt = 1'b0;
    tick();
    check_val("resume_latency", 32'(pe3), 32'b001);

    // Restart aborts the cycle in progress without counting it.
    wait_p3_pos(1);
    saved_cnt = cnt3;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_val("restart_phase", 32'(pe3), 32'b001);
    check_val("restart_count", 32'(cnt3), 32'(saved_cnt));
    repeat (3) tick();

    // Asynchronous reset landing mid-phase.
    async_reset_pulse();
    repeat (4) tick();

    // Randomised control traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) halt = ~halt;
      step    = ($urandom_range(0, 2) == 0);
      restart = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) async_reset_pulse();
      tick();
    end

    // Long free run so the 8-bit counter wraps.
    halt = 1'b0; step = 1'b0; restart = 1'b0;
    async_reset_pulse();
    wrapped_seen = 1'b0;
    for (int i = 0; i < 256 * 5 + 10; i++) begin
      tick();
      if (m_cnt[1] == 0 && m_pos[1] == 0 && i > 20) wrapped_seen = 1'b1;
    end
    check_val("p5_wrap_reached", 32'(wrapped_seen), 32'd1);
    check_val("p3_count_after_run", 32'(cnt3), 32'(m_cnt[0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter NUM_PHASES, default 3, number of phase enables per machine cycle; legal range 2..8.
REQ-002 Parameter CNT_W, default 16, width of completed-cycle counter; legal range 8..32.
REQ-003 Localparam IDX_W = clog2(NUM_PHASES), minimum 1.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 halt  input  1  level request to stop at the next machine-cycle boundary.
REQ-007 step  input  1  single-step request, sampled only in HALTED.
REQ-008 restart  input  1  synchronous abort of the current cycle; returns to phase 0.
REQ-009 phase_en  output  NUM_PHASES  one-hot-or-zero phase enables; bit i active during phase i.
REQ-010 phase_idx  output  IDX_W  current phase pointer.
REQ-011 cycle_last  output  1  high while the final phase (NUM_PHASES-1) is enabled.
REQ-012 running  output  1  high in RUN or STEP.
REQ-013 cycle_count  output  CNT_W  number of completed machine cycles.

Function
REQ-014 State machine SHALL have exactly three states: HALTED, RUN, STEP.
REQ-015 phase_en[i] SHALL be 1 iff state != HALTED and phase_idx == i; SHALL be decoded only from registered state (no input-to-output combinational path).
REQ-016 In RUN/STEP, phase_idx SHALL advance by 1 per clock; from NUM_PHASES-1 it SHALL wrap to 0.
REQ-017 A cycle completes on the edge where state != HALTED and phase_idx == NUM_PHASES-1; cycle_count SHALL increment by 1 on that edge, wrapping from 2^CNT_W-1 to 0.
REQ-018 RUN, completing edge, halt=1 -> HALTED, phase_idx=0; halt=0 -> stays RUN.
REQ-019 RUN, non-completing edge: halt SHALL NOT interrupt the cycle; phases always complete atomically.
REQ-020 HALTED: phase_idx held at 0, all phase_en 0; halt=0 -> RUN; halt=1 and step=1 -> STEP; otherwise stay.
REQ-021 STEP SHALL execute exactly one full machine cycle (NUM_PHASES clocks); on its completing edge -> HALTED if halt=1, else RUN.
REQ-022 step SHALL be ignored in RUN and STEP; a step held high SHALL cause one further STEP per return to HALTED.
REQ-023 restart=1 SHALL override all other transitions: phase_idx<=0, state<=HALTED if halt=1 else RUN, cycle_count unchanged (aborted cycle not counted).
REQ-024 Latency: from HALTED with halt falling, phase_en[0] SHALL assert in the clock following the first sampling edge (1-cycle latency).
REQ-025 cycle_last SHALL equal phase_en[NUM_PHASES-1].
REQ-026 running SHALL be 1 iff state is RUN or STEP.

Reset
REQ-027 reset=1 SHALL immediately and asynchronously force state=HALTED, phase_idx=0, cycle_count=0, hence phase_en=0, cycle_last=0, running=0.
REQ-028 reset asserted mid-cycle SHALL abort the cycle without counting it; behaviour after release SHALL follow REQ-020.
REQ-029 All outputs SHALL be held at reset values while reset=1 regardless of halt, step, restart.

Verification
REQ-030 NUM_PHASES=3, reset released with halt=0 -> phase_en sequence 000,001,010,100,001,...; cycle_count=1 after third enabled phase.
REQ-031 Halt raised while phase_en=010 -> 100 still occurs, then 000, running=0, phase_idx=0, cycle_count incremented once.
REQ-032 HALTED, halt=1, one-clock step pulse -> exactly 001,010,100 then 000; cycle_count +1; step held 10 clocks -> repeated 3-phase bursts, each separated by one HALTED clock.
REQ-033 RUN at phase_en=010, restart=1 one clock -> next phase_en=001, cycle_count unchanged.
REQ-034 NUM_PHASES=5, CNT_W=8: run 256 cycles -> cycle_count wraps to 0; phase_idx wraps 4->0; cycle_last high only when phase_idx=4.
REQ-035 Reset asserted asynchronously mid-phase (between edges) -> phase_en=0 and cycle_count=0 before the next rising edge.
